// File: rtl/fifo_drain_arb.sv
// Round-robin read-side controller: drains fixed-length bursts from a byte FIFO
// to one of two valid/ready consumers. Optional stall abort via BURST_TIMEOUT_EN.
module fifo_drain_arb #(
   parameter int dato_width  = 8,
   parameter int burst_len   = 53,
   parameter int cnt_width   = 6,
   parameter int timeout_cyc = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  fifo_empy_i,
   input  logic                  fifo_dato_i,
   input  logic [dato_width-1:0] fifo_datout_i,
   output logic                  fifo_rd_o,
   input  logic [1:0]            req_i,
   output logic [1:0]            gnt_o,
   output logic [dato_width-1:0] dout_o,
   output logic                  dout_valid_o,
   input  logic                  dout_ready_i,
   output logic                  dout_first_o,
   output logic                  dout_last_o,
`ifdef BURST_TIMEOUT_EN
   output logic                  abort_o,
`endif
   output logic                  busy_o,
   output logic [cnt_width-1:0]  burst_cnt_o
);
   typedef enum logic [2:0] {IDLE, ARB, READ, CAPT, OUT, DONE} state_t;
   localparam logic [cnt_width-1:0] LAST_CNT = cnt_width'(burst_len - 1);

   state_t                  state_q, state_d;
   logic [1:0]              gnt_q, gnt_d;
   logic                    prev_q, prev_d;   // index of the consumer granted most recently
   logic [dato_width-1:0]   dout_q, dout_d;
   logic                    valid_q, valid_d;
   logic                    first_q, first_d;
   logic                    lastw_q, lastw_d;
   logic [cnt_width-1:0]    cnt_q, cnt_d;
`ifdef BURST_TIMEOUT_EN
   localparam int SW = $clog2(timeout_cyc + 1);
   localparam logic [SW-1:0] STALL_LIM = SW'(timeout_cyc - 1);
   logic [SW-1:0]           stall_q, stall_d;
   logic                    abort_q, abort_d;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         gnt_q   <= 2'b00;
         prev_q  <= 1'b1;   // so that a tie after reset goes to req[0]
         dout_q  <= '0;
         valid_q <= 1'b0;
         first_q <= 1'b0;
         lastw_q <= 1'b0;
         cnt_q   <= '0;
`ifdef BURST_TIMEOUT_EN
         stall_q <= '0;
         abort_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         prev_q  <= prev_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         first_q <= first_d;
         lastw_q <= lastw_d;
         cnt_q   <= cnt_d;
`ifdef BURST_TIMEOUT_EN
         stall_q <= stall_d;
         abort_q <= abort_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      prev_d    = prev_q;
      dout_d    = dout_q;
      valid_d   = valid_q;
      first_d   = first_q;
      lastw_d   = lastw_q;
      cnt_d     = cnt_q;
      fifo_rd_o = 1'b0;
`ifdef BURST_TIMEOUT_EN
      stall_d   = stall_q;
      abort_d   = 1'b0;
`endif
      case (state_q)
         IDLE: if (req_i != 2'b00 && fifo_dato_i) state_d = ARB;
         ARB: begin
            state_d = READ;
            if (req_i == 2'b01 || (req_i == 2'b11 && prev_q)) begin
               gnt_d  = 2'b01;
               prev_d = 1'b0;
            end else if (req_i[1]) begin
               gnt_d  = 2'b10;
               prev_d = 1'b1;
            end else begin
               state_d = IDLE;   // request withdrawn during arbitration
            end
         end
         READ: begin
            if (!fifo_empy_i) begin
               fifo_rd_o = 1'b1;
               state_d   = CAPT;
`ifdef BURST_TIMEOUT_EN
               stall_d   = '0;
`endif
            end
`ifdef BURST_TIMEOUT_EN
            else if (stall_q == STALL_LIM) begin
               state_d = DONE;
               abort_d = 1'b1;
               gnt_d   = 2'b00;
               cnt_d   = '0;
               stall_d = '0;
            end else begin
               stall_d = stall_q + 1'b1;
            end
`endif
         end
         CAPT: begin
            dout_d  = fifo_datout_i;
            valid_d = 1'b1;
            first_d = (cnt_q == '0);
            lastw_d = (cnt_q == LAST_CNT);
            state_d = OUT;
         end
         OUT: if (dout_ready_i) begin
            valid_d = 1'b0;
            first_d = 1'b0;
            lastw_d = 1'b0;
            if (lastw_q) begin
               // clear on entry so DONE already shows an idle grant and zero count
               state_d = DONE;
               gnt_d   = 2'b00;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               state_d = READ;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign gnt_o        = gnt_q;
   assign dout_o       = dout_q;
   assign dout_valid_o = valid_q;
   assign dout_first_o = first_q;
   assign dout_last_o  = lastw_q;
   assign burst_cnt_o  = cnt_q;
   assign busy_o       = (state_q != IDLE);
`ifdef BURST_TIMEOUT_EN
   assign abort_o      = abort_q;
`endif
endmodule

// File: doc/fifo_drain_arb.md
Name: fifo_drain_arb

Overview:
- Single-clock read-side controller for the 53-entry camera byte FIFO.
- Shares the FIFO read port between two downstream consumers using round-robin arbitration.
- Drains one fixed-length burst (default one 53-byte cell) per grant to the granted consumer over a valid/ready stream.
- Sits between the FIFO read interface (rd/datout/empy/full) and the packet consumers; it drives rd and rclk-domain sequencing.

Parameters:
- dato_width, 8: data width in bits; matches the FIFO word width.
- burst_len, 53: words per grant; legal range 1..63.
- cnt_width, 6: width of the burst counter; must satisfy 2^cnt_width > burst_len.
- timeout_cyc, 255: stall limit in cycles. Used only with BURST_TIMEOUT_EN.

Ports:
- clk, input, 1: single clock; also drives the FIFO rclk.
- rst, input, 1: asynchronous, active-low reset.
- fifo_empy, input, 1: FIFO empty flag.
- fifo_dato, input, 1: FIFO holds at least one word.
- fifo_datout, input, dato_width: FIFO read data, valid on the cycle after fifo_rd.
- fifo_rd, output, 1: FIFO read strobe; one pulse pops one word.
- req, input, 2: per-consumer burst request (level).
- gnt, output, 2: one-hot grant, held for the whole burst.
- dout, output, dato_width: stream data.
- dout_valid, output, 1: stream valid.
- dout_ready, input, 1: stream ready from the granted consumer.
- dout_first, output, 1: qualifies the first word of a burst.
- dout_last, output, 1: qualifies the final word of a burst.
- busy, output, 1: high when not in IDLE.
- burst_cnt, output, cnt_width: words delivered so far in the current burst.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; gnt=0; fifo_rd=0; dout=0; dout_valid=0; dout_first=0; dout_last=0; busy=0; burst_cnt=0.
  - Round-robin pointer favours req[0].
- State machine: IDLE -> ARB -> READ -> CAPT -> OUT -> (READ | DONE) -> IDLE.
- IDLE: when req!=0 and fifo_dato=1, go to ARB. With no data, requests wait; gnt stays 0.
- ARB (1 cycle):
  - Only one request active: grant it.
  - Both active: grant the requester that was not granted last.
  - Update the pointer; gnt is registered and becomes one-hot on entry to READ.
- READ:
  - If fifo_empy=0: assert fifo_rd for exactly one cycle, then go to CAPT.
  - If fifo_empy=1: hold fifo_rd=0 and stay in READ (stall).
- CAPT:
  - Register fifo_datout into dout.
  - Set dout_valid=1.
  - dout_first=1 when burst_cnt=0; dout_last=1 when burst_cnt=burst_len-1.
  - Go to OUT.
- OUT:
  - Hold dout, dout_valid, dout_first and dout_last stable until dout_ready=1.
  - On the handshake edge: dout_valid drops, burst_cnt increments.
  - Next state is DONE if this was the last word, else READ.
- DONE (1 cycle): gnt=0, burst_cnt=0, then go to IDLE.
- Latency and throughput:
  - req to first fifo_rd: 2 cycles (IDLE, ARB).
  - Best case is 1 word per 3 cycles (READ, CAPT, OUT with dout_ready=1).
- Requests and grants:
  - A req drop mid-burst is ignored; the burst always completes.
  - A consumer re-raising req after DONE loses to a waiting peer.
  - gnt never changes inside a burst and is never two-hot.
- fifo_rd is never asserted when fifo_empy=1, and at most once per delivered word.
- burst_cnt never exceeds burst_len-1 while busy.
- A reset mid-burst returns everything to reset values immediately.
  - Words already popped are lost; no FIFO recovery is attempted.

Optional Feature:
- Macro: BURST_TIMEOUT_EN.
- Defined:
  - A cycle counter runs while in READ with fifo_empy=1 and clears on every pop.
  - When the counter reaches timeout_cyc, the burst aborts: go to DONE and pulse abort output (1 bit, extra port) for one cycle.
  - The pulse is coincident with DONE. No partial dout_last is issued.
- Undefined: the abort port and counter are absent, and READ stalls indefinitely.

Test Plan:
1. Single requester:
   - Stimulus: fill the FIFO with 0x00..0x34, hold req=01, dout_ready=1.
   - Response: gnt=01; 53 words 0x00..0x34 in order; dout_first on 0x00, dout_last on 0x34; exactly 53 fifo_rd pulses; then gnt=00.
2. Simultaneous requests:
   - Stimulus: req=11 with the FIFO holding 106 words.
   - Response: the first burst goes to gnt=01, the second to gnt=10, and neither is interleaved.
3. Backpressure:
   - Stimulus: toggle dout_ready low for 5 cycles on word 10.
   - Response: dout holds word 10 stable, no extra fifo_rd, burst_cnt frozen at 10.
4. Underflow stall:
   - Stimulus: only 20 words present at grant, then write 33 more after 40 cycles.
   - Response: fifo_rd stops after 20 pops and resumes afterwards; the burst completes with 53 words.
5. Reset mid-burst:
   - Stimulus: rst=0 asynchronously at word 30.
   - Response: all outputs go to reset values before the next clk edge; after release, the next grant goes to req[0] first.
6. Timeout (BURST_TIMEOUT_EN, timeout_cyc=255):
   - Stimulus: leave the FIFO empty at word 5.
   - Response: abort pulses one cycle at stall cycle 255; gnt=00; burst_cnt=0.
